// File: rtl/run_intr_decode_pkg.sv
// run_intr_decode_pkg: shared definitions for the run-interruption decoder.
//   state_t      - decoder FSM state encoding (ESC only with RUN_DEC_LIMIT_EN)
//   N_RESET      - context occurrence count at which A, N and Nn are halved
//   QBPP_DEFAULT - default bits per sample (escape-code suffix length)
// Build option: RUN_DEC_LIMIT_EN enables limited-length (escape) codes.
package run_intr_decode_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNARY  = 3'd1,
      SUFFIX = 3'd2,
`ifdef RUN_DEC_LIMIT_EN
      ESC    = 3'd3,
`endif
      MAP    = 3'd4
   } state_t;

   localparam int unsigned N_RESET      = 64;
   localparam int unsigned QBPP_DEFAULT = 8;

endpackage

// File: rtl/golomb_k.sv
// golomb_k: Golomb parameter selection.
//   n    (in, 7)  - context occurrence count N
//   temp (in, 14) - accumulated magnitude to cover
//   k    (out, 4) - smallest k with (n << k) >= temp, saturating at 15
module golomb_k (
   input  logic [6:0]  n,
   input  logic [13:0] temp,
   output logic [3:0]  k
);

   logic found;

   always_comb begin
      k     = 4'd15;
      found = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (!found && (({15'd0, n} << i) >= {8'd0, temp})) begin
            k     = 4'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/run_intr_decode.sv
// run_intr_decode: bit-serial decoder for run-interruption samples.
// Decodes one Golomb (optionally limited-length) code from an MSB-first
// bitstream, maps it to a signed error value and produces the updated context.
//   clk, reset           - clock; asynchronous active-low reset
//   start, RItype        - begin decode; run-interruption type (context select)
//   glimit               - limited-length code limit (used with RUN_DEC_LIMIT_EN)
//   A_0/A_1, N_0/N_1, Nn_0/Nn_1 - the two context sets
//   bit_valid, bit_in, bit_ready - bitstream handshake
//   busy, out_valid, err - status; out_valid/err are single-cycle pulses
//   Errval, EMErrval, k, A_Q_out, N_Q_out, Nn_Q_out - result, held until next out_valid
// Build option: RUN_DEC_LIMIT_EN adds escape-code handling driven by glimit;
// without it glimit is ignored and a unary run of 31 zeros is an error.
module run_intr_decode
   import run_intr_decode_pkg::*;
#(
   parameter int unsigned QBPP = QBPP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              RItype,
   input  logic [5:0]        glimit,
   input  logic [12:0]       A_0,
   input  logic [12:0]       A_1,
   input  logic [6:0]        N_0,
   input  logic [6:0]        N_1,
   input  logic [6:0]        Nn_0,
   input  logic [6:0]        Nn_1,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              bit_ready,
   output logic              busy,
   output logic              out_valid,
   output logic              err,
   output logic signed [8:0] Errval,
   output logic [8:0]        EMErrval,
   output logic [3:0]        k,
   output logic [12:0]       A_Q_out,
   output logic [6:0]        N_Q_out,
   output logic [6:0]        Nn_Q_out
);

   // Wide enough for q << k before the >256 check and for a QBPP-bit escape.
   localparam int unsigned MW = ((QBPP > 8) ? QBPP : 8) + 14;
   localparam int unsigned CW = 5;

   state_t            state, state_n;
   logic              ritype_r, ritype_n;
   logic [12:0]       a_r, a_n;
   logic [6:0]        n_r, n_n, nn_r, nn_n;
   logic [3:0]        k_r, k_n, k_start;
   logic [5:0]        q_r, q_n;
   logic [6:0]        q_inc;
   logic [MW-1:0]     mval_r, mval_n, mval_sh;
   logic [CW-1:0]     cnt_r, cnt_n, cnt_inc;
   logic [13:0]       temp_start;
   logic [6:0]        n_start;
   logic              take, q_over, q_at;

   logic [9:0]        t_val;
   logic              map_b, neg_b, err_neg;
   logic [8:0]        mag;
   logic signed [8:0] errval_c;
   logic [13:0]       a_sum;
   logic [7:0]        nn_sum;
   logic [12:0]       a_upd;
   logic [6:0]        nn_upd, n_upd;

   logic              out_valid_n, err_n;
   logic signed [8:0] errval_n;
   logic [8:0]        emerr_n;
   logic [3:0]        k_out_n;
   logic [12:0]       a_out_n;
   logic [6:0]        n_out_n, nn_out_n;

   assign n_start    = RItype ? N_1 : N_0;
   assign temp_start = RItype ? ({1'b0, A_1} + {8'd0, N_1[6:1]}) : {1'b0, A_0};

   golomb_k u_golomb_k (
      .n    (n_start),
      .temp (temp_start),
      .k    (k_start)
   );

   assign busy      = (state != IDLE);
   assign bit_ready = (state == UNARY) || (state == SUFFIX)
`ifdef RUN_DEC_LIMIT_EN
                      || (state == ESC)
`endif
                      ;
   assign take    = bit_valid && bit_ready;
   assign q_inc   = {1'b0, q_r} + 7'd1;
   assign cnt_inc = cnt_r + 5'd1;
   assign mval_sh = {mval_r[MW-2:0], bit_in};

`ifdef RUN_DEC_LIMIT_EN
   logic [5:0]        glimit_r, glimit_n;
   logic signed [7:0] lim;

   // Unary length at which the escape code takes over: glimit - QBPP - 1.
   assign lim    = $signed({2'b00, glimit_r}) - $signed(8'(QBPP + 1));
   assign q_over = $signed({1'b0, q_inc}) > lim;
   assign q_at   = $signed({2'b00, q_r}) == lim;
`else
   logic unused_glimit;

   assign unused_glimit = ^glimit;
   assign q_over        = (q_inc == 7'd31);
   assign q_at          = 1'b0;
`endif

   // Error mapping and context update, evaluated from the registered MErrval.
   always_comb begin
      t_val    = mval_r[9:0] + {9'd0, ritype_r};
      map_b    = t_val[0];
      mag      = 9'(({1'b0, t_val} + {10'd0, map_b}) >> 1);
      neg_b    = ((k_r == 4'd0) && ({nn_r, 1'b0} < {1'b0, n_r})) ? ~map_b : map_b;
      err_neg  = neg_b && (mag != 9'd0);
      errval_c = (mag == 9'd0) ? '0 : (neg_b ? -$signed(mag) : $signed(mag));
      a_sum    = {1'b0, a_r} + {4'd0, 10'((mval_r[9:0] + 10'd1 - {9'd0, ritype_r}) >> 1)};
      nn_sum   = {1'b0, nn_r} + {7'd0, err_neg};
      if (n_r == 7'(N_RESET)) begin
         a_upd  = a_sum[13:1];
         nn_upd = nn_sum[7:1];
         n_upd  = {1'b0, n_r[6:1]} + 7'd1;
      end else begin
         a_upd  = a_sum[12:0];
         nn_upd = nn_sum[6:0];
         n_upd  = n_r + 7'd1;
      end
   end

   always_comb begin
      state_n     = state;
      ritype_n    = ritype_r;
      a_n         = a_r;
      n_n         = n_r;
      nn_n        = nn_r;
      k_n         = k_r;
      q_n         = q_r;
      mval_n      = mval_r;
      cnt_n       = cnt_r;
`ifdef RUN_DEC_LIMIT_EN
      glimit_n    = glimit_r;
`endif
      out_valid_n = 1'b0;
      err_n       = 1'b0;
      errval_n    = Errval;
      emerr_n     = EMErrval;
      k_out_n     = k;
      a_out_n     = A_Q_out;
      n_out_n     = N_Q_out;
      nn_out_n    = Nn_Q_out;

      case (state)
         IDLE: begin
            if (start) begin
               state_n  = UNARY;
               ritype_n = RItype;
               a_n      = RItype ? A_1 : A_0;
               n_n      = n_start;
               nn_n     = RItype ? Nn_1 : Nn_0;
               k_n      = k_start;
               q_n      = '0;
               mval_n   = '0;
               cnt_n    = '0;
`ifdef RUN_DEC_LIMIT_EN
               glimit_n = glimit;
`endif
            end
         end
         UNARY: begin
            if (take) begin
               if (!bit_in) begin
                  if (q_over) begin
                     err_n   = 1'b1;
                     q_n     = '0;
                     state_n = IDLE;
                  end else begin
                     q_n = q_inc[5:0];
                  end
               end else if (q_at) begin
`ifdef RUN_DEC_LIMIT_EN
                  state_n = ESC;
`endif
                  mval_n  = '0;
                  cnt_n   = '0;
               end else if (k_r != 4'd0) begin
                  state_n = SUFFIX;
                  mval_n  = MW'(q_r);
                  cnt_n   = '0;
               end else begin
                  state_n = MAP;
                  mval_n  = MW'(q_r);
               end
            end
         end
         SUFFIX: begin
            if (take) begin
               mval_n = mval_sh;
               cnt_n  = cnt_inc;
               if (cnt_inc == {1'b0, k_r}) state_n = MAP;
            end
         end
`ifdef RUN_DEC_LIMIT_EN
         ESC: begin
            if (take) begin
               cnt_n = cnt_inc;
               if (cnt_inc == CW'(QBPP)) begin
                  mval_n  = mval_sh + MW'(1);
                  state_n = MAP;
               end else begin
                  mval_n = mval_sh;
               end
            end
         end
`endif
         MAP: begin
            state_n = IDLE;
            if (mval_r > MW'(256)) begin
               err_n = 1'b1;
            end else begin
               out_valid_n = 1'b1;
               errval_n    = errval_c;
               emerr_n     = mval_r[8:0];
               k_out_n     = k_r;
               a_out_n     = a_upd;
               n_out_n     = n_upd;
               nn_out_n    = nn_upd;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ritype_r  <= 1'b0;
         a_r       <= '0;
         n_r       <= '0;
         nn_r      <= '0;
         k_r       <= '0;
         q_r       <= '0;
         mval_r    <= '0;
         cnt_r     <= '0;
`ifdef RUN_DEC_LIMIT_EN
         glimit_r  <= '0;
`endif
         out_valid <= 1'b0;
         err       <= 1'b0;
         Errval    <= '0;
         EMErrval  <= '0;
         k         <= '0;
         A_Q_out   <= '0;
         N_Q_out   <= '0;
         Nn_Q_out  <= '0;
      end else begin
         ritype_r  <= ritype_n;
         a_r       <= a_n;
         n_r       <= n_n;
         nn_r      <= nn_n;
         k_r       <= k_n;
         q_r       <= q_n;
         mval_r    <= mval_n;
         cnt_r     <= cnt_n;
`ifdef RUN_DEC_LIMIT_EN
         glimit_r  <= glimit_n;
`endif
         out_valid <= out_valid_n;
         err       <= err_n;
         Errval    <= errval_n;
         EMErrval  <= emerr_n;
         k         <= k_out_n;
         A_Q_out   <= a_out_n;
         N_Q_out   <= n_out_n;
         Nn_Q_out  <= nn_out_n;
      end
   end

endmodule

// File: tb/tb_run_intr_decode.sv
// tb_run_intr_decode: table-driven bench for run_intr_decode with a result
// scoreboard, plus hand-written sequences for stalls, start-while-busy and
// mid-code reset. Escape vectors are selected with RUN_DEC_LIMIT_EN.
module tb_run_intr_decode;

   typedef struct {
      logic        ritype;
      logic [12:0] a;
      logic [6:0]  n;
      logic [6:0]  nn;
      logic [5:0]  glimit;
      int unsigned nbits;
      logic [63:0] bits;
      logic        exp_err;
      int          exp_k;
      int          exp_em;
      int          exp_ev;
      int          exp_a;
      int          exp_n;
      int          exp_nn;
   } vec_t;

   logic              clk, reset, start, RItype, bit_valid, bit_in;
   logic [5:0]        glimit;
   logic [12:0]       A_0, A_1;
   logic [6:0]        N_0, N_1, Nn_0, Nn_1;
   logic              bit_ready, busy, out_valid, err;
   logic signed [8:0] Errval;
   logic [8:0]        EMErrval;
   logic [3:0]        k;
   logic [12:0]       A_Q_out;
   logic [6:0]        N_Q_out, Nn_Q_out;

   int    checks = 0;
   int    failures = 0;
   int    ov_count = 0;
   int    err_count = 0;
   int    exp_ov = 0;
   int    exp_errs = 0;
   string cur = "init";
   vec_t  sb[$];
   vec_t  vecs[$];

   run_intr_decode #(.QBPP(8)) dut (
      .clk(clk), .reset(reset), .start(start), .RItype(RItype), .glimit(glimit),
      .A_0(A_0), .A_1(A_1), .N_0(N_0), .N_1(N_1), .Nn_0(Nn_0), .Nn_1(Nn_1),
      .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
      .busy(busy), .out_valid(out_valid), .err(err),
      .Errval(Errval), .EMErrval(EMErrval), .k(k),
      .A_Q_out(A_Q_out), .N_Q_out(N_Q_out), .Nn_Q_out(Nn_Q_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset && out_valid) ov_count++;
      if (reset && err) err_count++;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", cur, name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ri, input int a, input int n, input int nn,
                               input int gl, input int nb, input longint bits,
                               input logic e, input int ek, input int em, input int ev,
                               input int ea, input int en, input int enn);
      vec_t v;
      v.ritype = ri;      v.a = 13'(a);        v.n = 7'(n);      v.nn = 7'(nn);
      v.glimit = 6'(gl);  v.nbits = nb;        v.bits = 64'(bits);
      v.exp_err = e;      v.exp_k = ek;        v.exp_em = em;    v.exp_ev = ev;
      v.exp_a = ea;       v.exp_n = en;        v.exp_nn = enn;
      return v;
   endfunction

   task automatic wait_idle();
      int unsigned c = 0;
      while (busy && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   // Drive the selected context; the other set gets unrelated values.
   task automatic apply_ctx(input vec_t v);
      RItype = v.ritype;
      glimit = v.glimit;
      if (v.ritype) begin
         A_1 = v.a; N_1 = v.n; Nn_1 = v.nn;
         A_0 = 13'd55; N_0 = 7'd11; Nn_0 = 7'd5;
      end else begin
         A_0 = v.a; N_0 = v.n; Nn_0 = v.nn;
         A_1 = 13'd77; N_1 = 7'd9; Nn_1 = 7'd3;
      end
   endtask

   task automatic scramble_ctx();
      RItype = ~RItype;
      glimit = 6'd10;
      A_0 = 13'h1ABC; A_1 = 13'h0F0F; N_0 = 7'd100; N_1 = 7'd1; Nn_0 = 7'd50; Nn_1 = 7'd60;
   endtask

   task automatic send_bit(input logic b, input bit jitter, output bit ok);
      ok = 1'b0;
      for (int unsigned g = 0; g < 64 && !ok; g++) begin
         bit_in    = b;
         bit_valid = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bit_valid && bit_ready) ok = 1'b1;
         @(negedge clk);
      end
      bit_valid = 1'b0;
   endtask

   // Called on the negedge following the last consumed bit.
   task automatic await_result();
      vec_t        e;
      int unsigned c = 0;
      bit          seen = 1'b0;
      check("latency_gap", longint'(out_valid), 0);
      while (!seen && c < 40) begin
         if (out_valid || err) seen = 1'b1;
         else begin
            @(negedge clk);
            c++;
         end
      end
      if (!seen) begin
         check("result_timeout", 1, 0);
         if (sb.size() > 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
         check("unexpected_output", 1, 0);
      end else begin
         e = sb.pop_front();
         check("err", longint'(err), longint'(e.exp_err));
         check("out_valid", longint'(out_valid), longint'(!e.exp_err));
         if (!e.exp_err) begin
            check("latency", longint'(c), 1);
            check("k", longint'(k), e.exp_k);
            check("EMErrval", longint'(EMErrval), e.exp_em);
            check("Errval", longint'($signed(Errval)), e.exp_ev);
            check("A_Q_out", longint'(A_Q_out), e.exp_a);
            check("N_Q_out", longint'(N_Q_out), e.exp_n);
            check("Nn_Q_out", longint'(Nn_Q_out), e.exp_nn);
         end
         @(negedge clk);
         check("pulse_width", longint'({out_valid, err}), 0);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit jitter, input bit poke);
      bit ok = 1'b1;
      wait_idle();
      apply_ctx(v);
      sb.push_back(v);
      if (v.exp_err) exp_errs++;
      else exp_ov++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_ctx();
      for (int unsigned i = 0; i < v.nbits && ok; i++) begin
         send_bit(v.bits[v.nbits-1-i], jitter, ok);
         if (!ok) check("bit_timeout", 1, 0);
         if (poke && i == 0) begin
            check("busy_on_poke", longint'(busy), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      await_result();
   endtask

   initial begin
      bit ok;
      reset = 1'b0; start = 1'b0; RItype = 1'b0; glimit = '0;
      A_0 = '0; A_1 = '0; N_0 = '0; N_1 = '0; Nn_0 = '0; Nn_1 = '0;
      bit_valid = 1'b0; bit_in = 1'b0;

      // ri, A, N, Nn, glimit, nbits, bits(MSB first), err, k, EM, Errval, A', N', Nn'
      vecs.push_back(mk(0,    4,  1,  0, 63,  3, 'b110,   0,  2,   2,    1,    5,  2,  0));
      vecs.push_back(mk(1,    0,  2,  0, 63,  2, 'b01,    0,  0,   1,   -1,    0,  3,  1));
      vecs.push_back(mk(0,  100, 64, 10, 63,  2, 'b11,    0,  1,   1,   -1,   50, 33,  5));
      vecs.push_back(mk(0,   10,  4,  0, 63,  5, 'b00101, 0,  2,   9,   -5,   15,  5,  1));
      vecs.push_back(mk(0,    0,  2,  1, 63,  4, 'b0001,  0,  0,   3,   -2,    2,  3,  2));
      vecs.push_back(mk(0,    0,  3,  1, 63,  2, 'b01,    0,  0,   1,    1,    1,  4,  1));
      vecs.push_back(mk(0,    0,  5,  0, 63,  1, 'b1,     0,  0,   0,    0,    0,  6,  0));
      vecs.push_back(mk(1,    0,  4,  0, 63,  1, 'b1,     0,  0,   0,    1,    0,  5,  0));
      vecs.push_back(mk(1,  200, 64, 20, 63,  3, 'b111,   0,  2,   3,    2,  100, 33, 10));
      vecs.push_back(mk(0, 1000,  1,  0, 63, 11, 'h4FF,   0, 10, 255, -128, 1128,  2,  1));
      vecs.push_back(mk(0, 1000,  1,  0, 63, 12, 'h400,   1,  0,   0,    0,    0,  0,  0));
      vecs.push_back(mk(0, 1000,  1,  0, 63, 11, 'h500,   0, 10, 256,  128, 1128,  2,  0));
      vecs.push_back(mk(0,    0,  1,  0, 63, 31, 'h1,     0,  0,  30,  -15,   15,  2,  1));
`ifdef RUN_DEC_LIMIT_EN
      vecs.push_back(mk(0,    4,  1,  0, 23, 23, 'h13F,   0,  2,  64,   32,   36,  2,  0));
      vecs.push_back(mk(0,    4,  1,  0, 23, 16, 'h4,     0,  2,  52,   26,   30,  2,  0));
      vecs.push_back(mk(0,    4,  1,  0, 23, 15, 'h0,     1,  0,   0,    0,    0,  0,  0));
`else
      vecs.push_back(mk(0,    0,  1,  0, 63, 31, 'h0,     1,  0,   0,    0,    0,  0,  0));
`endif

      cur = "reset";
      @(negedge clk);
      check("outputs", longint'({Errval, EMErrval, k, A_Q_out, N_Q_out, Nn_Q_out}), 0);
      check("flags", longint'({busy, bit_ready, out_valid, err}), 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         cur = $sformatf("v%0d", i);
         run_vec(vecs[i], 1'b0, 1'b0);
      end
      for (int i = 0; i < vecs.size(); i++) begin
         cur = $sformatf("jit_v%0d", i);
         run_vec(vecs[i], 1'b1, 1'b0);
      end

      cur = "poke_busy";
      run_vec(vecs[0], 1'b1, 1'b1);

      // Abort a code partway through its suffix.
      cur = "reset_mid";
      wait_idle();
      apply_ctx(vecs[0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_bit(1'b1, 1'b0, ok);
      send_bit(1'b1, 1'b0, ok);
      check("busy_mid", longint'({busy, bit_ready}), 3);
      #2 reset = 1'b0;
      #1;
      check("outputs", longint'({Errval, EMErrval, k, A_Q_out, N_Q_out, Nn_Q_out}), 0);
      check("flags", longint'({busy, bit_ready, out_valid, err}), 0);
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      check("hold", longint'({busy, bit_ready, out_valid, err}), 0);
      bit_valid = 1'b0;
      start     = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("idle_after", longint'(busy), 0);

      cur = "after_reset";
      run_vec(vecs[0], 1'b1, 1'b0);

      cur = "totals";
      repeat (5) @(negedge clk);
      check("out_valid_count", ov_count, exp_ov);
      check("err_count", err_count, exp_errs);
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
